// File: rtl/kaipokrandt_mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch (IF) and load/store (LS).
// Sequences ADDR -> ACCESS (wait MFC, watchdog) -> DONE -> IDLE; tie-break alternates.
module kaipokrandt_mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req_if,
  input  logic req_ls,
  input  logic ls_rw,
  input  logic MFC,
  output logic mar_sel,
  output logic mar_load,
  output logic mem_en,
  output logic mem_rw,
  output logic gnt_if,
  output logic gnt_ls,
  output logic done_if,
  output logic done_ls,
  output logic timeout,
  output logic busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_ACCESS, S_DONE} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state, state_n;
  logic          owner, owner_n;     // 0 = IF, 1 = LS
  logic          rw_q, rw_n;
  logic          last_ls, last_ls_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          to_q, to_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      rw_q    <= 1'b1;
      last_ls <= 1'b1;
      cnt     <= '0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      rw_q    <= rw_n;
      last_ls <= last_ls_n;
      cnt     <= cnt_n;
      to_q    <= to_n;
    end
  end

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    rw_n      = rw_q;
    last_ls_n = last_ls;
    cnt_n     = cnt;
    to_n      = to_q;
    case (state)
      S_IDLE: begin
        if (req_if || req_ls) begin
          // On a tie, LS wins only if IF was served last.
          owner_n = (req_if && req_ls) ? ~last_ls : req_ls;
          rw_n    = owner_n ? ls_rw : 1'b1;
          cnt_n   = '0;
          to_n    = 1'b0;
          state_n = S_ADDR;
        end
      end
      S_ADDR:   state_n = S_ACCESS;
      S_ACCESS: begin
        if (MFC) begin
          state_n = S_DONE;
        end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
          to_n    = 1'b1;
          state_n = S_DONE;
        end else if (cnt != {CW{1'b1}}) begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE: begin
        last_ls_n = owner;
        state_n   = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == S_ADDR) || (state == S_ACCESS);
    gnt_if   = (state != S_IDLE) && !owner;
    gnt_ls   = (state != S_IDLE) && owner;
    mar_load = (state == S_ADDR);
    mar_sel  = (state == S_ADDR) && owner;
    mem_en   = (state == S_ACCESS);
    mem_rw   = (state == S_ACCESS) && rw_q;
    done_if  = (state == S_DONE) && !owner;
    done_ls  = (state == S_DONE) && owner;
    timeout  = (state == S_DONE) && to_q;
  end

endmodule

// File: tb/tb_kaipokrandt_mem_arbiter.sv
// Directed and randomized transactions against a cycle-offset reference model of the arbiter.
module tb_kaipokrandt_mem_arbiter;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_if = 1'b0, req_ls = 1'b0, ls_rw = 1'b0, MFC = 1'b0;
  logic mar_sel, mar_load, mem_en, mem_rw, gnt_if, gnt_ls;
  logic done_if, done_ls, timeout, busy;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int done_exp = 0;
  bit m_last_ls = 1'b1;

  kaipokrandt_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_if(req_if), .req_ls(req_ls), .ls_rw(ls_rw), .MFC(MFC),
    .mar_sel(mar_sel), .mar_load(mar_load), .mem_en(mem_en), .mem_rw(mem_rw),
    .gnt_if(gnt_if), .gnt_ls(gnt_ls), .done_if(done_if), .done_ls(done_ls),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  wire [9:0] outv = {mar_sel, mar_load, mem_en, mem_rw, gnt_if, gnt_ls,
                     done_if, done_ls, timeout, busy};

  always @(negedge clk) if (done_if || done_ls) done_seen++;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Expected outputs 'off' cycles after the grant cycle, for an access that spends n cycles in ACCESS.
  function automatic logic [9:0] expect_vec(input bit w, input bit rw, input int off,
                                            input int n, input bit to);
    logic [9:0] v;
    v = '0;
    if (off == 1) begin
      v = {w, 1'b1, 1'b0, 1'b0, !w, w, 1'b0, 1'b0, 1'b0, 1'b1};
    end else if (off >= 2 && off <= n + 1) begin
      v = {1'b0, 1'b0, 1'b1, rw, !w, w, 1'b0, 1'b0, 1'b0, 1'b1};
    end else if (off == n + 2) begin
      v = {1'b0, 1'b0, 1'b0, 1'b0, !w, w, !w, w, to, 1'b0};
    end
    return v;
  endfunction

  // k < TIMEOUT: MFC on ACCESS cycle k; otherwise MFC never arrives.
  task automatic run_txn(input string tag, input bit rif, input bit rls, input bit lsrw,
                         input int k, input bit drop);
    bit w, rw, to;
    int n;
    @(negedge clk);
    check({tag, "_idle"}, outv, 10'b0);
    req_if = rif; req_ls = rls; ls_rw = lsrw; MFC = 1'($urandom);
    w  = (rif && rls) ? !m_last_ls : rls;
    rw = w ? lsrw : 1'b1;
    to = (k >= TIMEOUT);
    n  = to ? TIMEOUT : k + 1;
    for (int off = 1; off <= n + 2; off++) begin
      @(negedge clk);
      check($sformatf("%s_off%0d", tag, off), outv, expect_vec(w, rw, off, n, to));
      ls_rw = 1'($urandom);
      if (off >= 2 && off <= n + 1) MFC = (!to && off - 2 == k);
      else MFC = 1'($urandom);
      if ((drop && off == 1) || off == n + 2) begin
        if (w) req_ls = 1'b0; else req_if = 1'b0;
      end
    end
    m_last_ls = w;
    done_exp++;
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_outputs", outv, 10'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_no_req", outv, 10'b0);

    // 1: IF alone, MFC on second ACCESS cycle
    run_txn("t1_if", 1, 0, 0, 1, 0);
    // 2: LS write, MFC first ACCESS cycle
    run_txn("t2_ls_wr", 0, 1, 0, 0, 0);
    // 3: sustained tie alternates starting with IF (last was LS)
    run_txn("t3_tie_a", 1, 1, 1, 0, 0);
    run_txn("t3_tie_b", 1, 1, 1, 0, 0);
    run_txn("t3_tie_c", 1, 1, 0, 2, 0);
    run_txn("t3_tie_d", 1, 1, 0, 1, 0);
    // 4: watchdog expiry on an LS read
    run_txn("t4_wdog", 0, 1, 1, TIMEOUT, 0);
    // 5: MFC coincident with expiry wins
    run_txn("t5_mfc_last", 1, 0, 0, TIMEOUT - 1, 0);
    // Requester drops request mid-transaction
    run_txn("drop_ls", 0, 1, 1, 3, 1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit rif, rls;
      int k;
      rif = 1'($urandom);
      rls = rif ? 1'($urandom) : 1'b1;
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 2))
                                       : int'($urandom_range(0, 3));
      run_txn($sformatf("rnd%0d", i), rif, rls, 1'($urandom), k, 1'($urandom));
    end

    // 6: reset asserted during ACCESS
    @(negedge clk);
    check("t6_pre_idle", outv, 10'b0);
    req_ls = 1'b1; ls_rw = 1'b1; MFC = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_in_access", outv, expect_vec(1'b1, 1'b1, 3, TIMEOUT, 1'b0));
    #2 reset = 1'b0;
    #1 check("t6_async_clear", outv, 10'b0);
    req_ls = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t6_held_in_reset", outv, 10'b0);
    end
    reset = 1'b1;
    m_last_ls = 1'b1;
    run_txn("t6_tie_after_reset", 1, 1, 0, 0, 0);

    repeat (2) @(negedge clk);
    checks++;
    assert (done_seen == done_exp) else begin
      errors++;
      $error("FAIL done_count: observed %0d expected %0d", done_seen, done_exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
